// File: rtl/load_pkg.sv
// Shared encodings for the load alignment unit: access sizes and FSM states.
package load_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_READ = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Natural alignment check; a reserved size never counts as misaligned here.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SIZE_HALF) && addr_lo[0]) ||
             ((size == SIZE_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/lane_extend.sv
// Picks the addressed byte/half lane out of a little-endian word and zero/sign extends it.
module lane_extend
   import load_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[8*i_addr_lo +: 8];
   assign w_half = i_word[16*i_addr_lo[1] +: 16];

   always_comb begin
      o_result = i_word;
      case (i_size)
         SIZE_BYTE: o_result = {{24{w_byte[7]  & ~i_unsigned}}, w_byte};
         SIZE_HALF: o_result = {{16{w_half[15] & ~i_unsigned}}, w_half};
         default:   o_result = i_word;
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// Single-outstanding load unit: word read, lane extraction, extension, ack timeout.
// Optional macro LOAD_MISALIGN_TRAP_EN: misaligned half/word loads fail without a memory access.
module load_align_unit
   import load_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rd_data,
   input  logic        mem_rd_ack,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        ld_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   state_t      r_state, w_state_nxt;
   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [31:0] r_ld_data, w_data_nxt;
   logic        r_ld_err, w_err_nxt;
   logic        w_accept;
   logic        w_bad_req;
   logic [31:0] w_ext;

`ifdef LOAD_MISALIGN_TRAP_EN
   assign w_bad_req = (req_size == SIZE_RSVD) || is_misaligned(req_size, req_addr[1:0]);
`else
   assign w_bad_req = (req_size == SIZE_RSVD);
`endif

   assign req_ready = (r_state == ST_IDLE);
   assign mem_rd_en = (r_state == ST_READ);
   assign ld_valid  = (r_state == ST_DONE);
   assign mem_addr  = {r_addr[31:2], 2'b00};
   assign ld_data   = r_ld_data;
   assign ld_err    = r_ld_err;
   assign w_accept  = req_valid && req_ready;

   lane_extend u_lane_extend (
      .i_word     (mem_rd_data),
      .i_addr_lo  (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_result   (w_ext)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_ld_data;
      w_err_nxt   = r_ld_err;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_cnt_nxt = '0;
               if (w_bad_req) begin
                  w_state_nxt = ST_DONE;
                  w_data_nxt  = '0;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_state_nxt = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (mem_rd_ack) begin
               w_state_nxt = ST_DONE;
               w_data_nxt  = w_ext;
               w_err_nxt   = 1'b0;
            end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               // Last allowed READ cycle passed without an ack.
               w_state_nxt = ST_DONE;
               w_data_nxt  = '0;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_ld_data  <= '0;
         r_ld_err   <= 1'b0;
         r_addr     <= '0;
         r_size     <= SIZE_BYTE;
         r_unsigned <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ld_data <= w_data_nxt;
         r_ld_err  <= w_err_nxt;
         if (w_accept) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
         end
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: directed table, corner sequences, random loads.
module tb_load_align_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rd_data;
   logic        mem_rd_ack;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_err;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   load_align_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .mem_rd_data  (mem_rd_data),
      .mem_rd_ack   (mem_rd_ack),
      .ld_valid     (ld_valid),
      .ld_data      (ld_data),
      .ld_err       (ld_err)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Reference result: derived from size/alignment rules with plain arithmetic.
   typedef struct {
      logic [31:0] data;
      logic        err;
      int          lat;
      logic        rd;
   } res_t;

   function automatic res_t model(input logic [31:0] addr, input logic [1:0] size,
                                  input logic uns, input logic [31:0] word, input int ack);
      res_t   r;
      longint w, v, span;
      int     off, nb;
      r.data = 0; r.err = 0; r.rd = 1; r.lat = 0;
      if (size == 2'd3) begin
         r.rd = 0; r.err = 1; r.lat = 1;
         return r;
      end
`ifdef LOAD_MISALIGN_TRAP_EN
      if ((size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0)) begin
         r.rd = 0; r.err = 1; r.lat = 1;
         return r;
      end
`endif
      if (ack < 1 || ack > 16) begin
         r.err = 1; r.lat = 17;
         return r;
      end
      r.lat = ack + 1;
      if (size == 2'd2) begin
         r.data = word;
      end else begin
         nb   = (size == 2'd0) ? 1 : 2;
         off  = (size == 2'd0) ? int'(addr % 4) : int'((addr % 4) / 2) * 2;
         w    = longint'(word);
         span = longint'(1) << (8 * nb);
         v    = (w >> (8 * off)) % span;
         if (!uns && v >= span / 2) v = v - span;
         r.data = 32'(v);
      end
      return r;
   endfunction

   // Issue one load at a negedge, ack in cycle 'ack' after accept (0 = never), check result.
   task automatic run_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] word, input int ack);
      res_t        exp;
      logic        seen, rd, addr_ok;
      logic [31:0] got_d;
      logic        got_e;
      int          cyc, lat;
      exp = model(addr, size, uns, word, ack);
      seen = 0; rd = 0; addr_ok = 1; got_d = 0; got_e = 0; lat = 0;
      chk({name, ".ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1; req_addr = addr; req_size = size; req_unsigned = uns;
      @(posedge clk); @(negedge clk);
      req_valid = 0; req_addr = $urandom; req_size = 2'($urandom); req_unsigned = 1'($urandom);
      cyc = 1;
      while (cyc <= 40) begin
         if (ld_valid) begin
            seen = 1; got_d = ld_data; got_e = ld_err; lat = cyc;
            break;
         end
         if (mem_rd_en) begin
            rd = 1;
            if (mem_addr !== {addr[31:2], 2'b00}) addr_ok = 0;
         end
         mem_rd_ack  = (cyc == ack);
         mem_rd_data = (cyc == ack) ? word : $urandom;
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      mem_rd_ack = 0;
      if (!seen) begin
         n_cmp++; n_fail++;
         $display("FAIL %s.no_ld_valid: got none within 40 cycles, expected one", name);
         return;
      end
      chk({name, ".data"}, got_d, exp.data);
      chk({name, ".err"}, {31'd0, got_e}, {31'd0, exp.err});
      chk({name, ".lat"}, lat, exp.lat);
      chk({name, ".rd_en"}, {31'd0, rd}, {31'd0, exp.rd});
      chk({name, ".maddr"}, {31'd0, addr_ok}, 32'd1);
      @(posedge clk); @(negedge clk);
      chk({name, ".pulse1"}, {31'd0, ld_valid}, 32'd0);
      chk({name, ".hold"}, ld_data, exp.data);
   endtask

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] word;
      int          ack;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[8];
   res_t m;

   initial begin
      vecs[0] = '{"byte_s_1003",  32'h1003, 2'd0, 1'b0, 32'h80F17F22, 2,  32'hFFFFFF80, 1'b0};
      vecs[1] = '{"half_u_1002",  32'h1002, 2'd1, 1'b1, 32'h80F17F22, 1,  32'h000080F1, 1'b0};
      vecs[2] = '{"half_s_1000",  32'h1000, 2'd1, 1'b0, 32'h80F17F22, 3,  32'h00007F22, 1'b0};
      vecs[3] = '{"word_2000",    32'h2000, 2'd2, 1'b0, 32'hDEADBEEF, 4,  32'hDEADBEEF, 1'b0};
      vecs[4] = '{"rsvd",         32'h2000, 2'd3, 1'b0, 32'hDEADBEEF, 1,  32'h00000000, 1'b1};
      vecs[5] = '{"ack_last",     32'h1001, 2'd0, 1'b1, 32'h80F17F22, 16, 32'h0000007F, 1'b0};
`ifdef LOAD_MISALIGN_TRAP_EN
      vecs[6] = '{"half_3001",    32'h3001, 2'd1, 1'b0, 32'h1234ABCD, 2,  32'h00000000, 1'b1};
      vecs[7] = '{"word_2003",    32'h2003, 2'd2, 1'b0, 32'hCAFEF00D, 1,  32'h00000000, 1'b1};
`else
      vecs[6] = '{"half_3001",    32'h3001, 2'd1, 1'b0, 32'h1234ABCD, 2,  32'hFFFFABCD, 1'b0};
      vecs[7] = '{"word_2003",    32'h2003, 2'd2, 1'b0, 32'hCAFEF00D, 1,  32'hCAFEF00D, 1'b0};
`endif

      rst_n = 0; req_valid = 0; req_addr = 0; req_size = 0; req_unsigned = 0;
      mem_rd_data = 0; mem_rd_ack = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.ld_valid", {31'd0, ld_valid}, 32'd0);
      chk("rst.ld_data", ld_data, 32'd0);
      chk("rst.ld_err", {31'd0, ld_err}, 32'd0);
      chk("rst.rd_en", {31'd0, mem_rd_en}, 32'd0);
      rst_n = 1;
      @(posedge clk); @(negedge clk);
      chk("rst.ready_after", {31'd0, req_ready}, 32'd1);

      // Directed table: model must agree with the hand-computed constants too.
      foreach (vecs[i]) begin
         m = model(vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].word, vecs[i].ack);
         chk({vecs[i].name, ".tbl_data"}, m.data, vecs[i].exp_data);
         chk({vecs[i].name, ".tbl_err"}, {31'd0, m.err}, {31'd0, vecs[i].exp_err});
         run_load(vecs[i].name, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].word, vecs[i].ack);
      end

      // Timeout, then a late ack while idle must not produce a result.
      run_load("timeout", 32'h4000, 2'd2, 1'b0, 32'h12345678, 0);
      chk("timeout.err_hold", {31'd0, ld_err}, 32'd1);
      mem_rd_ack = 1; mem_rd_data = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("late_ack.valid%0d", i), {31'd0, ld_valid}, 32'd0);
         chk($sformatf("late_ack.data%0d", i), ld_data, 32'd0);
         chk($sformatf("late_ack.rd%0d", i), {31'd0, mem_rd_en}, 32'd0);
      end
      mem_rd_ack = 0;

      // Reset in the middle of READ abandons the load.
      req_valid = 1; req_addr = 32'h5004; req_size = 2'd2; req_unsigned = 0;
      @(posedge clk); @(negedge clk);
      req_valid = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_read.in_read", {31'd0, mem_rd_en}, 32'd1);
      rst_n = 0;
      @(posedge clk); @(negedge clk);
      chk("rst_read.rd_en", {31'd0, mem_rd_en}, 32'd0);
      chk("rst_read.valid", {31'd0, ld_valid}, 32'd0);
      rst_n = 1;
      @(posedge clk); @(negedge clk);
      chk("rst_read.ready", {31'd0, req_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         mem_rd_ack = 1; mem_rd_data = $urandom;
         chk($sformatf("rst_read.quiet%0d", i), {31'd0, ld_valid}, 32'd0);
         @(posedge clk); @(negedge clk);
      end
      mem_rd_ack = 0;

      // Random loads against the reference model.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [1:0]  s;
         int          k;
         a = {$urandom_range(0, 255), 2'($urandom)};
         s = 2'($urandom_range(0, 3));
         k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 17));
         run_load($sformatf("rnd%0d", i), a, s, 1'($urandom), $urandom, k);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
